// File: rtl/frame_reader.sv
// frame_reader: maps display coordinates to image RAM reads with centred 1x/2x/4x scaling.
// Build macro TEST_PATTERN_EN enables mode 3 (XOR test pattern); default build leaves it disabled.
module frame_reader #(
  parameter int         SRC_W        = 160,
  parameter int         SRC_H        = 120,
  parameter int         MEM_LATENCY  = 2,
  parameter logic [7:0] BORDER_COLOR = 8'h00,
  parameter logic [1:0] DEFAULT_MODE = 2'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  next_x,
  input  logic [9:0]  next_y,
  input  logic        vsync,
  input  logic [1:0]  mode_in,
  input  logic        mode_valid,
  output logic        mode_ready,
  output logic [14:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [7:0]  color_out,
  output logic [1:0]  mode_active
);

  localparam int DLY = MEM_LATENCY + 1;

  localparam logic [10:0] W1   = 11'(SRC_W);
  localparam logic [10:0] W2   = 11'(2 * SRC_W);
  localparam logic [10:0] W4   = 11'(4 * SRC_W);
  localparam logic [10:0] H1   = 11'(SRC_H);
  localparam logic [10:0] H2   = 11'(2 * SRC_H);
  localparam logic [10:0] H4   = 11'(4 * SRC_H);
  localparam logic [10:0] X0_1 = 11'((640 - SRC_W) / 2);
  localparam logic [10:0] X0_2 = 11'((640 - 2 * SRC_W) / 2);
  localparam logic [10:0] X0_4 = 11'((640 - 4 * SRC_W) / 2);
  localparam logic [10:0] Y0_1 = 11'((480 - SRC_H) / 2);
  localparam logic [10:0] Y0_2 = 11'((480 - 2 * SRC_H) / 2);
  localparam logic [10:0] Y0_4 = 11'((480 - 4 * SRC_H) / 2);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  pending_q, pending_d;
  logic [1:0]  mode_active_q, mode_active_d;
  logic        mode_ready_q, mode_ready_d;
  logic        vsync_q, vsync_d;
  logic        frame_edge;
  logic        mode_ok;

  logic [14:0]    mem_addr_q, mem_addr_d;
  logic           mem_rd_q, mem_rd_d;
  logic [7:0]     color_q, color_d;
  logic [DLY-1:0] flag_q, flag_d;

  logic [10:0] x0, y0, w, h, px, py, dx, dy;
  logic [1:0]  shift;
  logic [9:0]  src_x, src_y;
  logic [14:0] addr;
  logic        in_image;
  logic        tp_mode;

`ifdef TEST_PATTERN_EN
  logic [DLY-1:0] tp_flag_q, tp_flag_d;
  logic [7:0]     tp_pix_q [DLY];
  logic [7:0]     tp_pix_d [DLY];

  assign tp_mode = (mode_active_q == 2'd3);
  assign mode_ok = 1'b1;

  always_comb begin
    tp_flag_d = {tp_flag_q[DLY-2:0], tp_mode};
    tp_pix_d[0] = next_x[7:0] ^ next_y[7:0];
    for (int i = 1; i < DLY; i++) tp_pix_d[i] = tp_pix_q[i-1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tp_flag_q <= '0;
      for (int i = 0; i < DLY; i++) tp_pix_q[i] <= 8'h00;
    end else begin
      tp_flag_q <= tp_flag_d;
      tp_pix_q  <= tp_pix_d;
    end
  end
`else
  assign tp_mode = 1'b0;
  // Without the pattern generator, a mode 3 request completes the handshake but is never applied.
  assign mode_ok = (pending_q != 2'd3);
`endif

  // Scaled window geometry for the mode in force when the coordinate is sampled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    x0    = X0_1;
    y0    = Y0_1;
    w     = W1;
    h     = H1;
    shift = 2'd0;
    case (mode_active_q)
      2'd1: begin x0 = X0_2; y0 = Y0_2; w = W2; h = H2; shift = 2'd1; end
      2'd2: begin x0 = X0_4; y0 = Y0_4; w = W4; h = H4; shift = 2'd2; end
      default: ;
    endcase

    px = {1'b0, next_x};
    py = {1'b0, next_y};
    in_image = !tp_mode && (px >= x0) && (px < x0 + w) && (py >= y0) && (py < y0 + h);

    dx    = px - x0;
    dy    = py - y0;
    src_x = 10'(dx >> shift);
    src_y = 10'(dy >> shift);

    if (SRC_W == 160) addr = (15'(src_y) << 7) + (15'(src_y) << 5) + 15'(src_x);
    else              addr = 15'(20'(src_y) * 20'(SRC_W)) + 15'(src_x);

    mem_rd_d   = in_image;
    mem_addr_d = in_image ? addr : mem_addr_q;

    // The flag travels alongside the RAM read so it lines up with mem_data.
    flag_d  = {flag_q[DLY-2:0], in_image};
    color_d = flag_q[DLY-1] ? mem_data : BORDER_COLOR;
`ifdef TEST_PATTERN_EN
    if (tp_flag_q[DLY-1]) color_d = tp_pix_q[DLY-1];
`endif
  end

  // NOTE: the pipeline shift registers are reset so nothing in flight survives a reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      color_q    <= 8'h00;
      flag_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      color_q    <= color_d;
      flag_q     <= flag_d;
    end
  end

  // Mode handshake; a new mode is applied only on a vsync falling edge.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    mode_active_d = mode_active_q;
    vsync_d       = vsync;
    frame_edge    = vsync_q && !vsync;
    case (state_q)
      IDLE: begin
        if (mode_valid) begin
          pending_d = mode_in;
          state_d   = PENDING;
        end
      end
      PENDING: begin
        if (frame_edge) begin
          state_d = IDLE;
          if (mode_ok) mode_active_d = pending_q;
        end
      end
    endcase
    mode_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pending_q     <= DEFAULT_MODE;
      mode_active_q <= DEFAULT_MODE;
      mode_ready_q  <= 1'b1;
      vsync_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      mode_active_q <= mode_active_d;
      mode_ready_q  <= mode_ready_d;
      vsync_q       <= vsync_d;
    end
  end

  assign mode_ready  = mode_ready_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign color_out   = color_q;
  assign mode_active = mode_active_q;

endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: directed stimulus for frame_reader, checked every cycle against a
// coordinate-level reference model plus literal expectations at the boundary cases.
module tb_frame_reader;

  localparam int         SRC_W  = 160;
  localparam int         SRC_H  = 120;
  localparam int         L      = 2;
  localparam int         DLY    = L + 1;
  localparam logic [7:0] BORDER = 8'h00;
`ifdef TEST_PATTERN_EN
  localparam bit TP_EN = 1'b1;
`else
  localparam bit TP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  next_x, next_y;
  logic        vsync;
  logic [1:0]  mode_in;
  logic        mode_valid;
  logic        mode_ready;
  logic [14:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [7:0]  color_out;
  logic [1:0]  mode_active;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  frame_reader #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .MEM_LATENCY(L),
    .BORDER_COLOR(BORDER), .DEFAULT_MODE(2'd1)
  ) dut (
    .clock(clock), .reset(reset), .next_x(next_x), .next_y(next_y),
    .vsync(vsync), .mode_in(mode_in), .mode_valid(mode_valid),
    .mode_ready(mode_ready), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .color_out(color_out), .mode_active(mode_active)
  );

  always #20 clock = ~clock;

  // Image RAM contents and its fixed read latency.
  function automatic logic [7:0] ram_val(input logic [14:0] a);
    return a[7:0] ^ {a[14:8], 1'b1} ^ 8'hA5;
  endfunction

  logic [7:0] rdpipe [L];
  always @(posedge clock) begin
    for (int i = L - 1; i > 0; i--) rdpipe[i] <= rdpipe[i-1];
    rdpipe[0] <= ram_val(mem_addr);
  end
  assign mem_data = rdpipe[L-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the screen pixel must be, from the geometry rules alone.
  function automatic void model_pixel(input int x, input int y, input int mode,
                                      output bit inimg, output int addr, output logic [7:0] pix);
    int s, w, h, x0, y0;
    s  = (mode == 1) ? 2 : (mode == 2) ? 4 : 1;
    w  = SRC_W * s;
    h  = SRC_H * s;
    x0 = (640 - w) / 2;
    y0 = (480 - h) / 2;
    inimg = (mode != 3) && x >= x0 && x < x0 + w && y >= y0 && y < y0 + h;
    addr  = inimg ? ((((y - y0) / s) * SRC_W + (x - x0) / s) % 32768) : 0;
    pix   = inimg ? ram_val(15'(addr)) : BORDER;
    if (TP_EN && mode == 3) pix = 8'(x ^ y);
  endfunction

  int          n = 0, base = 0;
  logic [7:0]  px_hist [8192];
  int          m_mode, m_req;
  bit          m_pending, vs_prev, m_rd;
  logic [14:0] m_addr;
  logic [7:0]  exp_color;
  bit          mi;
  int          ma;
  logic [7:0]  mp;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      base      = n;
      m_mode    = 1;
      m_req     = 0;
      m_pending = 1'b0;
      vs_prev   = 1'b1;
      m_rd      = 1'b0;
      m_addr    = '0;
      exp_color = 8'h00;
    end else begin
      model_pixel(int'(next_x), int'(next_y), m_mode, mi, ma, mp);
      px_hist[13'(n % 8192)] = mp;
      m_rd = mi;
      if (mi) m_addr = 15'(ma);
      exp_color = (n - DLY >= base) ? px_hist[13'((n - DLY) % 8192)] : BORDER;
      if (!m_pending) begin
        if (mode_valid) begin
          m_pending = 1'b1;
          m_req     = int'(mode_in);
        end
      end else if (vs_prev && !vsync) begin
        m_pending = 1'b0;
        if (m_req != 3 || TP_EN) m_mode = m_req;
      end
      vs_prev = vsync;
      n++;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("color_out",   32'(color_out),   32'(exp_color));
      check("mem_rd",      32'(mem_rd),      32'(m_rd));
      check("mem_addr",    32'(mem_addr),    32'(m_addr));
      check("mode_active", 32'(mode_active), 32'(m_mode));
      check("mode_ready",  32'(mode_ready),  32'(!m_pending));
    end
  end

  task automatic drive(input int x, input int y);
    next_x = 10'(x);
    next_y = 10'(y);
    @(posedge clock);
    #2;
  endtask

  task automatic sweep(input int cnt, input int seed);
    for (int i = 0; i < cnt; i++) drive((i * 37 + seed) % 640, (i * 53 + seed * 7) % 480);
  endtask

  initial begin
    reset = 1'b1; next_x = '0; next_y = '0; vsync = 1'b1; mode_in = '0; mode_valid = 1'b0;
    #5 reset = 1'b0;
    #1;
    check("rst_mem_rd",      32'(mem_rd),      0);
    check("rst_color",       32'(color_out),   0);
    check("rst_mem_addr",    32'(mem_addr),    0);
    check("rst_mode_active", 32'(mode_active), 1);
    check("rst_mode_ready",  32'(mode_ready),  1);
    chk_en = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;

    // 2x at the default mode.
    drive(163, 125);
    check("m1_addr",        32'(mem_addr),  321);
    check("m1_rd",          32'(mem_rd),    1);
    check("m1_first_color", 32'(color_out), 32'(BORDER));
    repeat (DLY) drive(0, 0);
    check("m1_color", 32'(color_out), 32'(ram_val(15'd321)));
    sweep(60, 1);

    // Request 4x mid-frame; a second request while pending is dropped.
    mode_in = 2'd2; mode_valid = 1'b1;
    drive(200, 200);
    check("req_ready_low", 32'(mode_ready),  0);
    check("req_mode_hold", 32'(mode_active), 1);
    mode_in = 2'd0;
    drive(201, 200);
    mode_valid = 1'b0;
    sweep(20, 3);
    check("pend_mode_hold", 32'(mode_active), 1);
    vsync = 1'b0;
    drive(210, 210);
    check("edge_mode_2",  32'(mode_active), 2);
    check("edge_ready_1", 32'(mode_ready),  1);
    drive(211, 210);
    drive(212, 210);
    vsync = 1'b1;
    drive(639, 479);
    check("m2_addr_max", 32'(mem_addr), 19199);
    drive(0, 0);
    check("m2_addr_min", 32'(mem_addr), 0);
    sweep(60, 5);

    // Request accepted on the same cycle as a frame edge waits for the next edge.
    mode_in = 2'd0; mode_valid = 1'b1; vsync = 1'b0;
    drive(100, 100);
    mode_valid = 1'b0;
    check("same_edge_hold",  32'(mode_active), 2);
    check("same_edge_ready", 32'(mode_ready),  0);
    drive(101, 100);
    vsync = 1'b1;
    sweep(10, 7);
    check("same_edge_still", 32'(mode_active), 2);
    vsync = 1'b0;
    drive(300, 200);
    check("next_edge_mode0", 32'(mode_active), 0);
    vsync = 1'b1;

    // 1x boundaries.
    drive(240, 180);
    check("m0_addr", 32'(mem_addr), 0);
    check("m0_rd",   32'(mem_rd),   1);
    drive(239, 180);
    check("m0_left_rd", 32'(mem_rd), 0);
    repeat (DLY - 1) drive(0, 0);
    check("m0_color_first", 32'(color_out), 32'(ram_val(15'd0)));
    drive(0, 0);
    check("m0_left_color", 32'(color_out), 32'(8'h00));
    sweep(60, 9);

    // Reset mid-frame with a read in flight.
    drive(300, 200);
    check("pre_rst_rd", 32'(mem_rd), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_rd",    32'(mem_rd),      0);
    check("mid_rst_color", 32'(color_out),   0);
    check("mid_rst_mode",  32'(mode_active), 1);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    drive(200, 200);
    check("post_rst_border", 32'(color_out), 32'(BORDER));
    repeat (DLY) drive(200, 200);
    check("post_rst_image", 32'(color_out), 32'(ram_val(15'((40 * SRC_W) + 20))));
    sweep(30, 11);

    // Mode 3 request.
    mode_in = 2'd3; mode_valid = 1'b1;
    drive(5, 3);
    mode_valid = 1'b0;
    vsync = 1'b0;
    drive(5, 3);
    vsync = 1'b1;
`ifdef TEST_PATTERN_EN
    check("tp_mode_active", 32'(mode_active), 3);
    repeat (DLY + 1) drive(5, 3);
    check("tp_color", 32'(color_out), 32'(8'h06));
    check("tp_rd",    32'(mem_rd),    0);
`else
    check("tp_mode_unchanged", 32'(mode_active), 1);
    check("tp_ready",          32'(mode_ready),  1);
    repeat (DLY + 1) drive(5, 3);
`endif
    sweep(20, 13);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SRC_W, 160, source image width in pixels.
- SRC_H, 120, source image height in pixels.
- MEM_LATENCY, 2, synchronous image RAM read latency in cycles, range 1..4.
- BORDER_COLOR, 8'h00, grey level for pixels outside the image.
- DEFAULT_MODE, 2'd1, mode loaded at reset.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clock  in  1  pixel clock, 25 MHz.
- reset  in  1  asynchronous, active-low.
- next_x  in  10  display column, 0..639.
- next_y  in  10  display row, 0..479.
- vsync  in  1  vertical sync from the display driver, active-low.
- mode_in  in  2  requested mode: 0 = 1x, 1 = 2x, 2 = 4x, 3 = test pattern.
- mode_valid  in  1  mode request strobe.
- mode_ready  out  1  request can be accepted.
- mem_addr  out  15  image RAM read address.
- mem_rd  out  1  image RAM read enable.
- mem_data  in  8  image RAM read data, valid MEM_LATENCY cycles after mem_addr/mem_rd.
- color_out  out  8  grey level feeding the display driver's color input.
- mode_active  out  2  mode currently applied.

Function
REQ-003 Scale s SHALL be 1, 2 or 4 for modes 0, 1, 2; displayed size SHALL be W=SRC_W*s, H=SRC_H*s, centred at x0=(640-W)/2, y0=(480-H)/2.
REQ-004 A pixel SHALL be in-image when x0<=next_x<x0+W and y0<=next_y<y0+H.
REQ-005 Source coordinates SHALL be src_x=(next_x-x0)>>log2(s) and src_y=(next_y-y0)>>log2(s), computed with shifts and subtraction only.
REQ-006 mem_addr SHALL equal src_y*SRC_W+src_x, using shift-add when SRC_W=160 ((y<<7)+(y<<5)), truncated to 15 bits.
REQ-007 Pipeline stage 1 SHALL register mem_addr and mem_rd; mem_rd SHALL be 1 only for in-image pixels, and mem_addr SHALL hold its previous value when mem_rd=0.
REQ-008 The in-image flag SHALL be delayed by MEM_LATENCY+1 cycles through a shift register so that it aligns with mem_data.
REQ-009 color_out SHALL be registered, equal to mem_data when the delayed flag is 1 and BORDER_COLOR otherwise.
REQ-010 Total latency from next_x/next_y to color_out SHALL be exactly MEM_LATENCY+2 cycles, constant for all modes.
REQ-011 Mode handshake SHALL use two states: IDLE (mode_ready=1) and PENDING (mode_ready=0).
REQ-012 In IDLE, mode_valid=1 SHALL capture mode_in into a pending register and move to PENDING.
REQ-013 In PENDING, mode_valid SHALL be ignored.
REQ-014 A frame edge is a vsync 1->0 transition detected on registered vsync; at a frame edge in PENDING, mode_active SHALL take the pending mode and the FSM SHALL return to IDLE.
REQ-015 A request accepted in the same cycle as a frame edge SHALL NOT be applied until the next frame edge.
REQ-016 mode_active SHALL change only at frame edges, so no frame ever mixes modes.
REQ-017 Pixels already in the pipeline at a mode change SHALL complete under the mode they were issued with.

Reset
REQ-018 reset=0 SHALL asynchronously clear mem_addr, mem_rd, color_out, the flag shift register, the registered vsync (to 1) and the FSM (to IDLE), and SHALL load mode_active with DEFAULT_MODE.
REQ-019 Reset asserted mid-frame SHALL discard all in-flight pixels, with no stale mem_data reaching color_out after release.
REQ-020 The first valid color_out after reset release SHALL appear MEM_LATENCY+2 cycles after the first sampled coordinate.

Configuration
REQ-021 Macro TEST_PATTERN_EN defined: mode 3 SHALL be accepted, keep mem_rd=0, and drive color_out=next_x[7:0]^next_y[7:0] with the same MEM_LATENCY+2 latency.
REQ-022 Macro TEST_PATTERN_EN undefined: a mode 3 request SHALL complete the handshake but SHALL leave mode_active unchanged at the frame edge.

Verification
REQ-023 Mode 1 (2x), next_x=163, next_y=125 -> mem_addr=321 and mem_rd=1 one cycle later; color_out=mem_data MEM_LATENCY+2 cycles after the coordinate.
REQ-024 Mode 0 (1x): next_x=240, next_y=180 -> mem_addr=0; next_x=239 -> mem_rd=0 and color_out=8'h00.
REQ-025 Mode 2 (4x): next_x=639, next_y=479 -> mem_addr=19199; next_x=0, next_y=0 -> mem_addr=0.
REQ-026 Send mode_valid with mode_in=2 mid-frame -> mode_ready drops, mode_active stays 1 until the next vsync falling edge, then becomes 2 and mode_ready=1; a second request while PENDING is dropped.
REQ-027 Assert reset while mem_rd=1 -> mem_rd=0, color_out=0, mode_active=1 immediately; after release, border pixels are output before image pixels with no stale data.
REQ-028 Request mode 3 with and without TEST_PATTERN_EN at next_x=5, next_y=3 -> color_out=8'h06 with the macro defined; mode_active unchanged without it.
